// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : BCD adjust constants and the op-strobe bundle for the ALU slice.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_bcd_adj = 4'd6;
    localparam logic [4:0] c_bcd_lim = 5'd9;
    localparam logic [4:0] c_nib_max = 5'd15;

    typedef struct packed {
        logic ands;
        logic eors;
        logic ors;
        logic srs;
        logic sums;
    } op_strobes_t;

endpackage
`default_nettype wire

// File: rtl/alu_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core_if
//  Purpose  : Control-side bundle between the ALU sequencer and the datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_core_if;

    logic       PHI1;
    logic       PHI2;
    logic [7:0] SB;
    logic [7:0] DB;
    logic [7:0] ADL;
    logic       NDB_ADD;
    logic       DB_ADD;
    logic       ADL_ADD;
    logic       SB_ADD;
    logic       Z_ADD;
    logic       ANDS;
    logic       EORS;
    logic       ORS;
    logic       SRS;
    logic       SUMS;
    logic       n_ACIN;
    logic       n_DAA;
    logic       n_DSA;
    logic       SB_AC;
    logic [7:0] ADD;
    logic       ACR;
    logic       AVR;
    logic       n_COUT;
    logic       DC3;
    logic [7:0] AC;

    modport master (
        output PHI1, PHI2, SB, DB, ADL, NDB_ADD, DB_ADD, ADL_ADD, SB_ADD, Z_ADD,
               ANDS, EORS, ORS, SRS, SUMS, n_ACIN, n_DAA, n_DSA, SB_AC,
        input  ADD, ACR, AVR, n_COUT, DC3, AC
    );

    modport slave (
        input  PHI1, PHI2, SB, DB, ADL, NDB_ADD, DB_ADD, ADL_ADD, SB_ADD, Z_ADD,
               ANDS, EORS, ORS, SRS, SUMS, n_ACIN, n_DAA, n_DSA, SB_AC,
        output ADD, ACR, AVR, n_COUT, DC3, AC
    );

endinterface
`default_nettype wire

// File: rtl/alu_bcd_adjust.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bcd_adjust
//  Purpose  : Per-nibble decimal correction applied on the SB -> AC transfer.
//  Revision : 1.0  initial release
// ============================================================================
module alu_bcd_adjust
    import alu_pkg::*;
(
    input  wire  [7:0] i_sb,
    input  wire        i_daa,
    input  wire        i_dsa,
    input  wire        i_acr,
    input  wire        i_dc3,
    output logic [7:0] o_corrected
);

    logic [3:0] w_lo;
    logic [3:0] w_hi;

    // Nibbles wrap independently; no carry or borrow crosses the boundary.
    always_comb begin
        w_lo = i_sb[3:0];
        w_hi = i_sb[7:4];
        if (i_daa) begin
            if (i_dc3) w_lo = w_lo + c_bcd_adj;
            if (i_acr) w_hi = w_hi + c_bcd_adj;
        end else if (i_dsa) begin
            if (!i_dc3) w_lo = w_lo - c_bcd_adj;
            if (!i_acr) w_hi = w_hi - c_bcd_adj;
        end
        o_corrected = {w_hi, w_lo};
    end

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : ALU datapath: input latches, logic/sum/shift result, flags, AC.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter bit HAS_BCD = 1'b1
) (
    input  wire        CLK,
    input  wire        n_RES,
    alu_core_if.slave  bus
);

    logic [7:0]  r_ai;
    logic [7:0]  r_bi;
    logic [7:0]  r_add;
    logic        r_acr;
    logic        r_avr;
    logic        r_dc3;
    logic [7:0]  r_ac;

    logic        w_tick1;
    logic        w_tick2;
    logic        w_daa;
    logic        w_dsa;
    op_strobes_t w_ops;
    logic        w_bi_sel;
    logic [7:0]  w_bi_new;
    logic [7:0]  w_and;
    logic [4:0]  w_lo;
    logic [4:0]  w_hi;
    logic        w_dc3_sum;
    logic        w_acr_sum;
    logic [7:0]  w_sum;
    logic [7:0]  w_res;
    logic        w_acr;
    logic        w_avr;
    logic        w_dc3;
    logic [7:0]  w_ac_fix;

    assign w_tick2 = bus.PHI2 & ~bus.PHI1;
    assign w_tick1 = bus.PHI1 & ~bus.PHI2;

    // DAA wins when both adjusts are requested; the 2A03 build has no BCD.
    assign w_daa = HAS_BCD & ~bus.n_DAA;
    assign w_dsa = HAS_BCD & ~bus.n_DSA & ~w_daa;

    assign w_ops = '{ands: bus.ANDS, eors: bus.EORS, ors: bus.ORS,
                     srs: bus.SRS, sums: bus.SUMS};

    // Selected BI sources are wire-ANDed onto the latch.
    assign w_bi_sel = bus.NDB_ADD | bus.DB_ADD | bus.ADL_ADD;
    assign w_bi_new = (bus.DB_ADD  ? bus.DB  : 8'hFF)
                    & (bus.NDB_ADD ? ~bus.DB : 8'hFF)
                    & (bus.ADL_ADD ? bus.ADL : 8'hFF);

    assign w_and = r_ai & r_bi;

    always_comb begin
        w_lo      = {1'b0, r_ai[3:0]} + {1'b0, r_bi[3:0]} + {4'd0, ~bus.n_ACIN};
        w_dc3_sum = (w_lo > c_nib_max) | (w_daa & (w_lo > c_bcd_lim));
        w_hi      = {1'b0, r_ai[7:4]} + {1'b0, r_bi[7:4]} + {4'd0, w_dc3_sum};
        w_acr_sum = (w_hi > c_nib_max) | (w_daa & (w_hi > c_bcd_lim));
        w_sum     = {w_hi[3:0], w_lo[3:0]};

        w_res = 8'h00;
        w_acr = 1'b0;
        w_avr = 1'b0;
        w_dc3 = 1'b0;
        if (w_ops.ands) w_res = w_res | w_and;
        if (w_ops.ors)  w_res = w_res | (r_ai | r_bi);
        if (w_ops.eors) w_res = w_res | (r_ai ^ r_bi);
        if (w_ops.srs) begin
            w_res = w_res | {1'b0, w_and[7:1]};
            w_acr = w_and[0];
        end
        if (w_ops.sums) begin
            w_res = w_res | w_sum;
            w_acr = w_acr | w_acr_sum;
            w_dc3 = w_dc3_sum;
            w_avr = ~(r_ai[7] ^ r_bi[7]) & (r_ai[7] ^ w_sum[7]);
        end
    end

    alu_bcd_adjust u_bcd_adjust (
        .i_sb        (bus.SB),
        .i_daa       (w_daa),
        .i_dsa       (w_dsa),
        .i_acr       (r_acr),
        .i_dc3       (r_dc3),
        .o_corrected (w_ac_fix)
    );

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            r_ai  <= 8'h00;
            r_bi  <= 8'h00;
            r_add <= 8'h00;
            r_acr <= 1'b0;
            r_avr <= 1'b0;
            r_dc3 <= 1'b0;
            r_ac  <= 8'h00;
        end else begin
            if (w_tick2) begin
                if (bus.Z_ADD)       r_ai <= 8'h00;
                else if (bus.SB_ADD) r_ai <= bus.SB;
                if (w_bi_sel)        r_bi <= w_bi_new;
            end
            // AC correction sees the flags from before this tick's update.
            if (w_tick1) begin
                r_add <= w_res;
                r_acr <= w_acr;
                r_avr <= w_avr;
                r_dc3 <= w_dc3;
                if (bus.SB_AC) r_ac <= w_ac_fix;
            end
        end
    end

    assign bus.ADD    = r_add;
    assign bus.ACR    = r_acr;
    assign bus.AVR    = r_avr;
    assign bus.n_COUT = ~r_acr;
    assign bus.DC3    = r_dc3;
    assign bus.AC     = r_ac;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_core
//  Purpose  : Directed and random checks of alu_core (BCD and 2A03 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_core;

    logic CLK = 1'b0;
    logic n_RES;
    always #5 CLK = ~CLK;

    logic       phi1, phi2, ndb_add, db_add, adl_add, sb_add, z_add;
    logic       ands, eors, ors, srs, sums, n_acin, n_daa, n_dsa, sb_ac;
    logic [7:0] sb, db, adl;

    alu_core_if ifa ();
    alu_core_if ifb ();

    assign ifa.PHI1    = phi1;    assign ifb.PHI1    = phi1;
    assign ifa.PHI2    = phi2;    assign ifb.PHI2    = phi2;
    assign ifa.SB      = sb;      assign ifb.SB      = sb;
    assign ifa.DB      = db;      assign ifb.DB      = db;
    assign ifa.ADL     = adl;     assign ifb.ADL     = adl;
    assign ifa.NDB_ADD = ndb_add; assign ifb.NDB_ADD = ndb_add;
    assign ifa.DB_ADD  = db_add;  assign ifb.DB_ADD  = db_add;
    assign ifa.ADL_ADD = adl_add; assign ifb.ADL_ADD = adl_add;
    assign ifa.SB_ADD  = sb_add;  assign ifb.SB_ADD  = sb_add;
    assign ifa.Z_ADD   = z_add;   assign ifb.Z_ADD   = z_add;
    assign ifa.ANDS    = ands;    assign ifb.ANDS    = ands;
    assign ifa.EORS    = eors;    assign ifb.EORS    = eors;
    assign ifa.ORS     = ors;     assign ifb.ORS     = ors;
    assign ifa.SRS     = srs;     assign ifb.SRS     = srs;
    assign ifa.SUMS    = sums;    assign ifb.SUMS    = sums;
    assign ifa.n_ACIN  = n_acin;  assign ifb.n_ACIN  = n_acin;
    assign ifa.n_DAA   = n_daa;   assign ifb.n_DAA   = n_daa;
    assign ifa.n_DSA   = n_dsa;   assign ifb.n_DSA   = n_dsa;
    assign ifa.SB_AC   = sb_ac;   assign ifb.SB_AC   = sb_ac;

    alu_core #(.HAS_BCD(1'b1)) u_dut_bcd (.CLK(CLK), .n_RES(n_RES), .bus(ifa));
    alu_core #(.HAS_BCD(1'b0)) u_dut_nes (.CLK(CLK), .n_RES(n_RES), .bus(ifb));

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: index 1 models the BCD build, index 0 the 2A03 build.
    int m_ai[2], m_bi[2], m_add[2], m_acr[2], m_avr[2], m_dc3[2], m_ac[2];

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ai[k] = 0; m_bi[k] = 0; m_add[k] = 0; m_acr[k] = 0;
            m_avr[k] = 0; m_dc3[k] = 0; m_ac[k] = 0;
        end
    endtask

    function automatic int nib_wrap(input int v);
        return ((v % 16) + 16) % 16;
    endfunction

    task automatic model_tick();
        int a, b, lo, hi, s, res, acr, avr, dc3, d, c, bv;
        bit daa, dsa;
        for (int k = 0; k < 2; k++) begin
            daa = (k == 1) && !n_daa;
            dsa = (k == 1) && !n_dsa && !daa;
            if (phi2 && !phi1) begin
                if (z_add)       m_ai[k] = 0;
                else if (sb_add) m_ai[k] = sb;
                if (ndb_add || db_add || adl_add) begin
                    bv = 255;
                    if (db_add)  bv = bv & db;
                    if (ndb_add) bv = bv & (255 - db);
                    if (adl_add) bv = bv & adl;
                    m_bi[k] = bv;
                end
            end else if (phi1 && !phi2) begin
                if (sb_ac) begin
                    lo = sb % 16; hi = sb / 16;
                    if (daa) begin
                        if (m_dc3[k] != 0) lo += 6;
                        if (m_acr[k] != 0) hi += 6;
                    end else if (dsa) begin
                        if (m_dc3[k] == 0) lo -= 6;
                        if (m_acr[k] == 0) hi -= 6;
                    end
                    m_ac[k] = nib_wrap(hi) * 16 + nib_wrap(lo);
                end
                a = m_ai[k]; b = m_bi[k];
                res = 0; acr = 0; avr = 0; dc3 = 0;
                if (ands) res |= a & b;
                if (ors)  res |= a | b;
                if (eors) res |= a ^ b;
                if (srs) begin
                    res |= (a & b) / 2;
                    acr = (a & b) % 2;
                end
                if (sums) begin
                    lo = a % 16 + b % 16 + (n_acin ? 0 : 1);
                    d  = ((lo > 15) || (daa && lo > 9)) ? 1 : 0;
                    hi = a / 16 + b / 16 + d;
                    c  = ((hi > 15) || (daa && hi > 9)) ? 1 : 0;
                    s  = (hi % 16) * 16 + lo % 16;
                    res |= s;
                    acr |= c;
                    dc3 = d;
                    avr = (((a >= 128) == (b >= 128)) && ((a >= 128) != (s >= 128))) ? 1 : 0;
                end
                m_add[k] = res; m_acr[k] = acr; m_avr[k] = avr; m_dc3[k] = dc3;
            end
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, "/bcd.ADD"},  ifa.ADD,           8'(m_add[1]));
        cmp({tag, "/bcd.ACR"},  {7'd0, ifa.ACR},    8'(m_acr[1]));
        cmp({tag, "/bcd.AVR"},  {7'd0, ifa.AVR},    8'(m_avr[1]));
        cmp({tag, "/bcd.COUT"}, {7'd0, ifa.n_COUT}, 8'(1 - m_acr[1]));
        cmp({tag, "/bcd.DC3"},  {7'd0, ifa.DC3},    8'(m_dc3[1]));
        cmp({tag, "/bcd.AC"},   ifa.AC,            8'(m_ac[1]));
        cmp({tag, "/nes.ADD"},  ifb.ADD,           8'(m_add[0]));
        cmp({tag, "/nes.ACR"},  {7'd0, ifb.ACR},    8'(m_acr[0]));
        cmp({tag, "/nes.AVR"},  {7'd0, ifb.AVR},    8'(m_avr[0]));
        cmp({tag, "/nes.COUT"}, {7'd0, ifb.n_COUT}, 8'(1 - m_acr[0]));
        cmp({tag, "/nes.DC3"},  {7'd0, ifb.DC3},    8'(m_dc3[0]));
        cmp({tag, "/nes.AC"},   ifb.AC,            8'(m_ac[0]));
    endtask

    task automatic idle();
        ndb_add = 0; db_add = 0; adl_add = 0; sb_add = 0; z_add = 0;
        ands = 0; eors = 0; ors = 0; srs = 0; sums = 0;
        n_acin = 1; n_daa = 1; n_dsa = 1; sb_ac = 0;
    endtask

    task automatic step(input string tag, input logic p1, input logic p2);
        phi1 = p1; phi2 = p2;
        model_tick();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d, input bit neg);
        idle();
        sb = a; sb_add = 1; db = d;
        if (neg) ndb_add = 1; else db_add = 1;
        step("load", 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        int op;
        idle();
        phi1 = 0; phi2 = 0; sb = 0; db = 0; adl = 0;
        n_RES = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        n_RES = 1;

        // Binary add with signed overflow
        load(8'h50, 8'h50, 1'b0);
        sums = 1; n_acin = 1;
        step("add", 1'b1, 1'b0);
        cmp("add.ADD", ifa.ADD, 8'hA0);
        cmp("add.AVR", {7'd0, ifa.AVR}, 8'h01);
        cmp("add.COUT", {7'd0, ifa.n_COUT}, 8'h01);

        // Subtract through inverted DB
        load(8'h05, 8'h03, 1'b1);
        sums = 1; n_acin = 0;
        step("sub", 1'b1, 1'b0);
        cmp("sub.ADD", ifa.ADD, 8'h02);
        cmp("sub.ACR", {7'd0, ifa.ACR}, 8'h01);

        // Decimal add, then corrected AC load
        load(8'h99, 8'h01, 1'b0);
        sums = 1; n_acin = 1; n_daa = 0;
        step("daa", 1'b1, 1'b0);
        cmp("daa.ADD", ifa.ADD, 8'hAA);
        cmp("daa.DC3", {7'd0, ifa.DC3}, 8'h01);
        cmp("daa.ACR", {7'd0, ifa.ACR}, 8'h01);
        cmp("nes_daa.ADD", ifb.ADD, 8'h9A);
        cmp("nes_daa.ACR", {7'd0, ifb.ACR}, 8'h00);
        idle();
        sb = 8'hAA; sb_ac = 1; n_daa = 0;
        step("daa_ac", 1'b1, 1'b0);
        cmp("daa_ac.AC", ifa.AC, 8'h00);
        cmp("nes_daa_ac.AC", ifb.AC, 8'hAA);

        // Decimal subtract, then corrected AC load
        load(8'h12, 8'hFA, 1'b0);
        sums = 1; n_acin = 0; n_dsa = 0;
        step("dsa", 1'b1, 1'b0);
        cmp("dsa.ADD", ifa.ADD, 8'h0D);
        cmp("dsa.DC3", {7'd0, ifa.DC3}, 8'h00);
        cmp("dsa.ACR", {7'd0, ifa.ACR}, 8'h01);
        idle();
        sb = 8'h0D; sb_ac = 1; n_dsa = 0;
        step("dsa_ac", 1'b1, 1'b0);
        cmp("dsa_ac.AC", ifa.AC, 8'h07);

        // Shift right
        load(8'hFF, 8'h81, 1'b0);
        srs = 1;
        step("srs", 1'b1, 1'b0);
        cmp("srs.ADD", ifa.ADD, 8'h40);
        cmp("srs.ACR", {7'd0, ifa.ACR}, 8'h01);

        // Hold on both or neither phase, with everything else active
        sb = 8'h3C; db = 8'hC3; sb_add = 1; db_add = 1; sums = 1; sb_ac = 1; n_acin = 0;
        step("hold11", 1'b1, 1'b1);
        step("hold00", 1'b0, 1'b0);

        // Random traffic with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            sb = 8'($urandom); db = 8'($urandom); adl = 8'($urandom);
            ndb_add = 1'($urandom); db_add = 1'($urandom); adl_add = 1'($urandom);
            sb_add = 1'($urandom); z_add = ($urandom_range(0, 3) == 0);
            n_acin = 1'($urandom); n_daa = 1'($urandom); n_dsa = 1'($urandom);
            sb_ac = 1'($urandom);
            op = $urandom_range(0, 3);
            sums = (op == 0);
            ands = (op != 0) && 1'($urandom);
            ors  = (op != 0) && 1'($urandom);
            eors = (op != 0) && 1'($urandom);
            srs  = (op != 0) && 1'($urandom);
            case ($urandom_range(0, 9))
                0:       step("rnd", 1'b1, 1'b1);
                1:       step("rnd", 1'b0, 1'b0);
                2, 3, 4: step("rnd", 1'b0, 1'b1);
                default: step("rnd", 1'b1, 1'b0);
            endcase
            if (i == 200) begin
                #2 n_RES = 0;
                #1;
                model_reset();
                check_all("midreset");
                @(posedge CLK);
                #1 n_RES = 1;
                check_all("postreset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_core.md
Name: alu_core

Overview:
- Datapath end of the ALU control interface. It consumes the latched ->ADD input selects, the ALU op strobes, carry-in and BCD strobes.
- It produces the ADD hold register, the carry and overflow flags, and the decimal-corrected accumulator.
- It sits between the internal buses (SB, DB, ADL) and the AC register, and returns n_COUT to the control side.
- It is single-clock: the PHI1 and PHI2 inputs act as phase qualifiers sampled on CLK.

Parameters:
- HAS_BCD, 1: when 0 (2A03 variant), n_DAA and n_DSA are ignored and always treated as 1.

Ports:
- CLK in 1: sole clock; all state updates on the rising edge.
- n_RES in 1: asynchronous, active-low reset.
- PHI1 in 1: phase-1 qualifier.
- PHI2 in 1: phase-2 qualifier.
- SB in 8: special bus value.
- DB in 8: data bus value.
- ADL in 8: address-low bus value.
- NDB_ADD, DB_ADD, ADL_ADD in 1 each: BI source selects.
- SB_ADD, Z_ADD in 1 each: AI source selects.
- ANDS, EORS, ORS, SRS, SUMS in 1 each: op strobes.
- n_ACIN in 1: carry in, active low.
- n_DAA in 1: decimal add adjust, active low.
- n_DSA in 1: decimal subtract adjust, active low.
- SB_AC in 1: load AC from SB with decimal correction.
- ADD out 8: ALU hold register.
- ACR out 1: carry out.
- AVR out 1: overflow.
- n_COUT out 1: inverted ACR, returned to control.
- DC3 out 1: nibble carry flag.
- AC out 8: accumulator.

Behaviour:
- Tick definitions: a PHI2 tick is a CLK rise with PHI2=1 and PHI1=0. A PHI1 tick is a CLK rise with PHI1=1 and PHI2=0. A rise with both or neither set holds all state.
- Reset: while n_RES=0, AI, BI, ADD and AC are 0x00, ACR=0, AVR=0, DC3=0, n_COUT=1. Reset takes effect asynchronously, including mid-operation; the first tick after release proceeds normally.
- PHI2 tick, AI: if Z_ADD, AI<=0x00; else if SB_ADD, AI<=SB; else AI holds. Z_ADD wins over SB_ADD.
- PHI2 tick, BI: BI <= bitwise AND of every selected source (DB, ~DB, ADL), modelling wired-AND; with none selected, BI holds.
- PHI1 tick, result: computed from AI, BI and the current strobes, then registered into ADD, ACR, AVR and DC3. Latency is one PHI2 tick plus one PHI1 tick from bus to ADD.
- Result value: bitwise OR of the results of all asserted strobes; no strobe gives 0x00 with ACR=0, AVR=0, DC3=0.
- ANDS: AI&BI.
- ORS: AI|BI.
- EORS: AI^BI.
- SRS: {0,(AI&BI)[7:1]}, with ACR=(AI&BI)[0].
- Non-SUMS flags: ACR=0 except under SRS; AVR=0; DC3=0.
- SUMS, with c0 = ~n_ACIN:
  - Low nibble: lo = AI[3:0]+BI[3:0]+c0. DC3 = (lo>15), or (lo>9) when DAA is active. ADD[3:0] = lo[3:0].
  - High nibble: hi = AI[7:4]+BI[7:4]+DC3. ACR = (hi>15), or (hi>9) when DAA is active. ADD[7:4] = hi[3:0].
  - AVR = ~(AI7^BI7) & (AI7^ADD7), computed on the new ADD.
  - DSA: carries stay binary.
- n_COUT: always ~ACR (registered alongside it).
- PHI1 tick with SB_AC=1: AC <= SB with per-nibble correction, using ACR and DC3 from before this tick.
  - DAA: +6 to the low nibble if DC3; +6 to the high nibble if ACR.
  - DSA: -6 to the low nibble if ~DC3; -6 to the high nibble if ~ACR.
  - Each nibble wraps mod 16; there is no carry or borrow between nibbles.
  - With neither DAA nor DSA, AC<=SB.
- DAA and DSA both active is illegal; DAA takes priority.
- With SB_AC=0, AC holds.

Decomposition:
- Shared package alu_pkg: BCD adjust constants (6, 9) and the op-strobe bundle struct {ands, eors, ors, srs, sums}.
- Sub-module alu_bcd_adjust: combinational per-nibble correction. Inputs: 8-bit SB, daa, dsa, acr, dc3. Output: 8-bit corrected value.

Test Plan:
- Reset: n_RES=0 mid-run -> immediately ADD=0x00, AC=0x00, n_COUT=1, AVR=0, DC3=0.
- Binary add: SB=0x50 with SB_ADD, DB=0x50 with DB_ADD, then SUMS with n_ACIN=1 -> ADD=0xA0, ACR=0, AVR=1, n_COUT=1.
- Subtract via NDB: AI=0x05, NDB_ADD with DB=0x03, n_ACIN=0, SUMS -> ADD=0x02, ACR=1, AVR=0.
- Decimal add: AI=0x99, BI=0x01, c0=0, DAA -> ADD=0xAA, DC3=1, ACR=1; then SB=0xAA with SB_AC and DAA -> AC=0x00.
- Decimal subtract: AI=0x12, BI=0xFA, c0=1, DSA -> ADD=0x0D, DC3=0, ACR=1; then SB_AC with DSA -> AC=0x07.
- SRS: AI=0xFF, BI=0x81 -> ADD=0x40, ACR=1.
- Hold: a CLK rise with PHI1=PHI2=1 leaves all state unchanged.
- HAS_BCD=0: repeat the decimal-add case -> ADD=0x9A, ACR=0, and AC=SB unchanged on load.
